// File: rtl/multicycle_control_fsm.sv
// Multi-cycle control sequencer for an RV32 subset datapath (shared PC/IR/ALUOut, unified memory).
// Moore outputs are registered alongside the state; only strobes gated by mem_ready or zero are combinational.
module multicycle_control_fsm #(
    parameter int MEM_TIMEOUT = 255,
    parameter int TO_W        = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [3:0] alu_control,
    output logic       reg_write,
    output logic [1:0] wb_sel,
    output logic       instr_retired,
    output logic [3:0] state,
    output logic       illegal,
    output logic       bus_error
);

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        EXEC_R    = 4'd2,
        EXEC_I    = 4'd3,
        MEM_ADDR  = 4'd4,
        MEM_READ  = 4'd5,
        MEM_WRITE = 4'd6,
        WB_ALU    = 4'd7,
        WB_MEM    = 4'd8,
        BRANCH    = 4'd9,
        JAL       = 4'd10,
        JALR      = 4'd11,
        TRAP      = 4'd15
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b0110;
    localparam logic [3:0] ALU_SRL  = 4'b0111;
    localparam logic [3:0] ALU_NONE = 4'b1111;

    localparam logic [1:0] SRC_A_PC     = 2'd0;
    localparam logic [1:0] SRC_A_RS1    = 2'd1;
    localparam logic [1:0] SRC_A_OLD_PC = 2'd2;
    localparam logic [1:0] SRC_B_RS2    = 2'd0;
    localparam logic [1:0] SRC_B_IMM    = 2'd1;
    localparam logic [1:0] SRC_B_FOUR   = 2'd2;
    localparam logic [1:0] WB_ALUOUT    = 2'd0;
    localparam logic [1:0] WB_MDR       = 2'd1;
    localparam logic [1:0] WB_PC        = 2'd2;

    localparam logic [TO_W-1:0] TIMEOUT_LIMIT = TO_W'(MEM_TIMEOUT);

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       mem_src;
        logic       pc_write;
        logic       pc_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_control;
        logic       reg_write;
        logic [1:0] wb_sel;
        logic       instr_retired;
    } ctrl_t;

    state_t            cur_state;
    state_t            nxt_state;
    ctrl_t             ctrl;
    logic [TO_W-1:0]   wait_cnt;
    logic              illegal_flag;
    logic              bus_error_flag;
    logic              timed_out;
    logic              fetch_done;
    logic              branch_taken;

    function automatic logic is_mem_state(input state_t s);
        return (s == FETCH) || (s == MEM_READ) || (s == MEM_WRITE);
    endfunction

    // Shift and add/sub variants share funct3; funct7 picks the arithmetic form.
    function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic [6:0] f7,
                                          input logic allow_sub);
        logic [3:0] op;
        op = ALU_NONE;
        case (f3)
            3'b000:  op = (allow_sub && f7 == F7_ALT) ? ALU_SUB : ALU_ADD;
            3'b111:  op = ALU_AND;
            3'b110:  op = ALU_OR;
            3'b100:  op = ALU_XOR;
            3'b001:  op = ALU_SLL;
            3'b101:  op = (f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
            default: op = ALU_NONE;
        endcase
        return op;
    endfunction

    function automatic logic is_legal(input logic [6:0] op, input logic [2:0] f3,
                                      input logic [6:0] f7);
        logic ok;
        ok = 1'b0;
        case (op)
            OP_R: begin
                if (f3 == 3'b010 || f3 == 3'b011) ok = 1'b0;
                else if (f7 == F7_BASE)           ok = 1'b1;
                else ok = (f7 == F7_ALT) && (f3 == 3'b000 || f3 == 3'b101);
            end
            OP_I: begin
                case (f3)
                    3'b010, 3'b011: ok = 1'b0;
                    3'b101:         ok = (f7 == F7_BASE) || (f7 == F7_ALT);
                    3'b001:         ok = (f7 == F7_BASE);
                    default:        ok = 1'b1;
                endcase
            end
            OP_LOAD, OP_STORE: ok = (f3 == 3'b010);
            OP_BRANCH:         ok = (f3 == 3'b000) || (f3 == 3'b001);
            OP_JAL:            ok = 1'b1;
            OP_JALR:           ok = (f3 == 3'b000);
            default:           ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Moore control word for a state; funct fields only matter in the execute states.
    function automatic ctrl_t moore_ctrl(input state_t s, input logic [2:0] f3,
                                         input logic [6:0] f7);
        ctrl_t c;
        c = '0;
        c.alu_control = ALU_NONE;
        case (s)
            FETCH: begin
                c.mem_req     = 1'b1;
                c.alu_src_a   = SRC_A_PC;
                c.alu_src_b   = SRC_B_FOUR;
                c.alu_control = ALU_ADD;
            end
            DECODE: begin
                c.alu_src_a   = SRC_A_OLD_PC;
                c.alu_src_b   = SRC_B_IMM;
                c.alu_control = ALU_ADD;
            end
            EXEC_R: begin
                c.alu_src_a   = SRC_A_RS1;
                c.alu_src_b   = SRC_B_RS2;
                c.alu_control = alu_op(f3, f7, 1'b1);
            end
            EXEC_I: begin
                c.alu_src_a   = SRC_A_RS1;
                c.alu_src_b   = SRC_B_IMM;
                c.alu_control = alu_op(f3, f7, 1'b0);
            end
            MEM_ADDR: begin
                c.alu_src_a   = SRC_A_RS1;
                c.alu_src_b   = SRC_B_IMM;
                c.alu_control = ALU_ADD;
            end
            MEM_READ: begin
                c.mem_req = 1'b1;
                c.mem_src = 1'b1;
            end
            MEM_WRITE: begin
                c.mem_req = 1'b1;
                c.mem_src = 1'b1;
                c.mem_we  = 1'b1;
            end
            WB_ALU: begin
                c.reg_write     = 1'b1;
                c.wb_sel        = WB_ALUOUT;
                c.instr_retired = 1'b1;
            end
            WB_MEM: begin
                c.reg_write     = 1'b1;
                c.wb_sel        = WB_MDR;
                c.instr_retired = 1'b1;
            end
            BRANCH: begin
                c.alu_src_a     = SRC_A_RS1;
                c.alu_src_b     = SRC_B_RS2;
                c.alu_control   = ALU_SUB;
                c.pc_src        = 1'b1;
                c.instr_retired = 1'b1;
            end
            JAL: begin
                c.pc_write      = 1'b1;
                c.pc_src        = 1'b1;
                c.reg_write     = 1'b1;
                c.wb_sel        = WB_PC;
                c.instr_retired = 1'b1;
            end
            JALR: begin
                c.alu_src_a     = SRC_A_RS1;
                c.alu_src_b     = SRC_B_IMM;
                c.alu_control   = ALU_ADD;
                c.pc_write      = 1'b1;
                c.reg_write     = 1'b1;
                c.wb_sel        = WB_PC;
                c.instr_retired = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

    assign timed_out = (wait_cnt == TIMEOUT_LIMIT);

    // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            FETCH: begin
                if (mem_ready)      nxt_state = DECODE;
                else if (timed_out) nxt_state = TRAP;
            end
            DECODE: begin
                if (!is_legal(opcode, funct3, funct7)) begin
                    nxt_state = TRAP;
                end else begin
                    case (opcode)
                        OP_R:              nxt_state = EXEC_R;
                        OP_I:              nxt_state = EXEC_I;
                        OP_LOAD, OP_STORE: nxt_state = MEM_ADDR;
                        OP_BRANCH:         nxt_state = BRANCH;
                        OP_JAL:            nxt_state = JAL;
                        OP_JALR:           nxt_state = JALR;
                        default:           nxt_state = TRAP;
                    endcase
                end
            end
            EXEC_R, EXEC_I: nxt_state = WB_ALU;
            MEM_ADDR:       nxt_state = (opcode == OP_LOAD) ? MEM_READ : MEM_WRITE;
            MEM_READ: begin
                if (mem_ready)      nxt_state = WB_MEM;
                else if (timed_out) nxt_state = TRAP;
            end
            MEM_WRITE: begin
                if (mem_ready)      nxt_state = FETCH;
                else if (timed_out) nxt_state = TRAP;
            end
            WB_ALU, WB_MEM, BRANCH, JAL, JALR: nxt_state = FETCH;
            TRAP:    nxt_state = TRAP;
            default: nxt_state = TRAP;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state      <= FETCH;
            ctrl           <= moore_ctrl(FETCH, funct3, funct7);
            wait_cnt       <= '0;
            illegal_flag   <= 1'b0;
            bus_error_flag <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            ctrl      <= moore_ctrl(nxt_state, funct3, funct7);
            if (nxt_state != cur_state)
                wait_cnt <= '0;
            else if (is_mem_state(cur_state) && !mem_ready)
                wait_cnt <= wait_cnt + 1'b1;
            if (cur_state == DECODE && nxt_state == TRAP)
                illegal_flag <= 1'b1;
            if (is_mem_state(cur_state) && nxt_state == TRAP)
                bus_error_flag <= 1'b1;
        end
    end

    assign fetch_done   = (cur_state == FETCH) && mem_ready;
    assign branch_taken = (cur_state == BRANCH) && ((funct3 == 3'b000) ? zero : !zero);
    assign state        = cur_state;

    // Reset overrides everything combinationally so no strobe survives the cycle rst rises.
    always_comb begin
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_src       = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_src        = 1'b0;
        alu_src_a     = SRC_A_PC;
        alu_src_b     = SRC_B_RS2;
        alu_control   = ALU_NONE;
        reg_write     = 1'b0;
        wb_sel        = WB_ALUOUT;
        instr_retired = 1'b0;
        illegal       = 1'b0;
        bus_error     = 1'b0;
        if (!rst) begin
            mem_req       = ctrl.mem_req;
            mem_we        = ctrl.mem_we;
            mem_src       = ctrl.mem_src;
            ir_write      = fetch_done;
            pc_write      = ctrl.pc_write | fetch_done | branch_taken;
            pc_src        = ctrl.pc_src;
            alu_src_a     = ctrl.alu_src_a;
            alu_src_b     = ctrl.alu_src_b;
            alu_control   = ctrl.alu_control;
            reg_write     = ctrl.reg_write;
            wb_sel        = ctrl.wb_sel;
            instr_retired = ctrl.instr_retired | ((cur_state == MEM_WRITE) && mem_ready);
            illegal       = illegal_flag;
            bus_error     = bus_error_flag;
        end
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: per-instruction expected cycle sequences, checked every cycle.
module tb_multicycle_control_fsm;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [3:0] A_AND = 4'b0000, A_OR  = 4'b0001, A_ADD = 4'b0010, A_SUB = 4'b0011;
    localparam logic [3:0] A_XOR = 4'b0100, A_SLL = 4'b0101, A_SRA = 4'b0110, A_SRL = 4'b0111;
    localparam logic [3:0] A_NONE = 4'b1111;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] opcode = '0;
    logic [2:0] funct3 = '0;
    logic [6:0] funct7 = '0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_we, mem_src, ir_write, pc_write, pc_src;
    logic [1:0] alu_src_a, alu_src_b, wb_sel;
    logic [3:0] alu_control, state;
    logic       reg_write, instr_retired, illegal, bus_error;

    always #5 clk = ~clk;

    multicycle_control_fsm #(.MEM_TIMEOUT(255), .TO_W(8)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .mem_src(mem_src), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
        .reg_write(reg_write), .wb_sel(wb_sel), .instr_retired(instr_retired),
        .state(state), .illegal(illegal), .bus_error(bus_error)
    );

    typedef struct packed {
        logic [3:0] st;
        logic       mem_req, mem_we, mem_src, ir_write, pc_write, pc_src;
        logic [1:0] src_a, src_b;
        logic [3:0] alu;
        logic       reg_write;
        logic [1:0] wb_sel;
        logic       ret, ill, berr;
    } obs_t;

    int    compared   = 0;
    int    mismatched = 0;
    int    cyc_count  = 0;
    int    start_cyc  = 0;
    int    last_lat   = -1;
    obs_t  exp_obs;
    logic  exp_valid  = 1'b0;
    string exp_name   = "";

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL %s: got %h, required %h", nm, got, want);
        end
    endtask

    // Single compare point: every driven cycle is checked at the falling edge.
    always @(negedge clk) begin
        if (exp_valid) begin
            obs_t got;
            got.st = state;          got.mem_req = mem_req;   got.mem_we = mem_we;
            got.mem_src = mem_src;   got.ir_write = ir_write; got.pc_write = pc_write;
            got.pc_src = pc_src;     got.src_a = alu_src_a;   got.src_b = alu_src_b;
            got.alu = alu_control;   got.reg_write = reg_write; got.wb_sel = wb_sel;
            got.ret = instr_retired; got.ill = illegal;       got.berr = bus_error;
            check(exp_name, {8'h00, got}, {8'h00, exp_obs});
            if (instr_retired === 1'b1) last_lat = cyc_count - start_cyc + 1;
            cyc_count++;
        end
    end

    function automatic obs_t blank(input logic [3:0] s);
        obs_t o;
        o = '0;
        o.st = s;
        o.alu = A_NONE;
        return o;
    endfunction

    function automatic obs_t fetch_obs(input logic rdy);
        obs_t o;
        o = blank(4'd0);
        o.mem_req = 1'b1; o.src_b = 2'd2; o.alu = A_ADD;
        o.ir_write = rdy; o.pc_write = rdy;
        return o;
    endfunction

    // Drives one clock cycle's inputs and blocks until its comparison has run.
    task automatic cycle(input string nm, input obs_t e, input logic rdy, input logic z,
                         input logic r);
        @(posedge clk);
        #1;
        rst = r; mem_ready = rdy; zero = z;
        exp_obs = e; exp_name = nm; exp_valid = 1'b1;
        @(negedge clk);
        #1;
    endtask

    task automatic set_ir(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        opcode = op; funct3 = f3; funct7 = f7;
    endtask

    task automatic do_reset(input string nm, input logic [3:0] from_state);
        cycle({nm, ":rst_rise"}, blank(from_state), 1'b0, 1'b0, 1'b1);
        cycle({nm, ":rst_hold"}, blank(4'd0), 1'b1, 1'b0, 1'b1);
    endtask

    task automatic fetch_decode(input string nm, input int fwait, input logic z);
        obs_t e;
        for (int i = 0; i <= fwait; i++)
            cycle({nm, ":fetch"}, fetch_obs(i == fwait), i == fwait, z, 1'b0);
        e = blank(4'd1); e.src_a = 2'd2; e.src_b = 2'd1; e.alu = A_ADD;
        cycle({nm, ":decode"}, e, 1'b1, z, 1'b0);
    endtask

    task automatic run_instr(input string nm, input logic [6:0] op, input logic [2:0] f3,
                             input logic [6:0] f7, input int fwait, input int mwait,
                             input logic z, input logic [3:0] ex_alu, input logic taken,
                             input int want_lat);
        obs_t e;
        set_ir(op, f3, f7);
        start_cyc = cyc_count;
        last_lat  = -1;
        fetch_decode(nm, fwait, z);
        case (op)
            OP_R, OP_I: begin
                e = blank(op == OP_R ? 4'd2 : 4'd3);
                e.src_a = 2'd1; e.src_b = (op == OP_I) ? 2'd1 : 2'd0; e.alu = ex_alu;
                cycle({nm, ":exec"}, e, 1'b1, z, 1'b0);
                e = blank(4'd7); e.reg_write = 1'b1; e.ret = 1'b1;
                cycle({nm, ":wb"}, e, 1'b1, z, 1'b0);
            end
            OP_LOAD, OP_STORE: begin
                e = blank(4'd4); e.src_a = 2'd1; e.src_b = 2'd1; e.alu = A_ADD;
                cycle({nm, ":addr"}, e, 1'b1, z, 1'b0);
                for (int i = 0; i <= mwait; i++) begin
                    e = blank(op == OP_LOAD ? 4'd5 : 4'd6);
                    e.mem_req = 1'b1; e.mem_src = 1'b1;
                    e.mem_we = (op == OP_STORE);
                    e.ret = (op == OP_STORE) && (i == mwait);
                    cycle({nm, ":mem"}, e, i == mwait, z, 1'b0);
                end
                if (op == OP_LOAD) begin
                    e = blank(4'd8); e.reg_write = 1'b1; e.wb_sel = 2'd1; e.ret = 1'b1;
                    cycle({nm, ":wbmem"}, e, 1'b1, z, 1'b0);
                end
            end
            OP_BRANCH: begin
                e = blank(4'd9); e.src_a = 2'd1; e.alu = A_SUB; e.pc_src = 1'b1;
                e.pc_write = taken; e.ret = 1'b1;
                cycle({nm, ":branch"}, e, 1'b1, z, 1'b0);
            end
            OP_JAL: begin
                e = blank(4'd10); e.pc_write = 1'b1; e.pc_src = 1'b1;
                e.reg_write = 1'b1; e.wb_sel = 2'd2; e.ret = 1'b1;
                cycle({nm, ":jal"}, e, 1'b1, z, 1'b0);
            end
            default: begin
                e = blank(4'd11); e.src_a = 2'd1; e.src_b = 2'd1; e.alu = A_ADD;
                e.pc_write = 1'b1; e.reg_write = 1'b1; e.wb_sel = 2'd2; e.ret = 1'b1;
                cycle({nm, ":jalr"}, e, 1'b1, z, 1'b0);
            end
        endcase
        check({nm, ":latency"}, last_lat, want_lat);
    endtask

    task automatic run_illegal(input string nm, input logic [6:0] op, input logic [2:0] f3,
                               input logic [6:0] f7, input int hold);
        obs_t e;
        set_ir(op, f3, f7);
        fetch_decode(nm, 0, 1'b0);
        for (int i = 0; i < hold; i++) begin
            e = blank(4'd15); e.ill = 1'b1;
            cycle({nm, ":trap"}, e, i[0], i[1], 1'b0);
        end
        check({nm, ":illegal_flag"}, illegal, 1);
        do_reset(nm, 4'd15);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t e;
        cycle("reset", blank(4'd0), 1'b0, 1'b0, 1'b1);

        //        name      opcode     f3      f7          fw  mw  z     alu    taken lat
        run_instr("add",    OP_R,      3'b000, 7'b0000000, 0,  0,  1'b0, A_ADD, 1'b0, 4);
        run_instr("sub",    OP_R,      3'b000, 7'b0100000, 1,  0,  1'b0, A_SUB, 1'b0, 5);
        run_instr("sra",    OP_R,      3'b101, 7'b0100000, 0,  0,  1'b0, A_SRA, 1'b0, 4);
        run_instr("srl",    OP_R,      3'b101, 7'b0000000, 0,  0,  1'b0, A_SRL, 1'b0, 4);
        run_instr("and",    OP_R,      3'b111, 7'b0000000, 0,  0,  1'b0, A_AND, 1'b0, 4);
        run_instr("or",     OP_R,      3'b110, 7'b0000000, 0,  0,  1'b0, A_OR,  1'b0, 4);
        run_instr("xor",    OP_R,      3'b100, 7'b0000000, 0,  0,  1'b0, A_XOR, 1'b0, 4);
        run_instr("sll",    OP_R,      3'b001, 7'b0000000, 2,  0,  1'b0, A_SLL, 1'b0, 6);
        run_instr("srli",   OP_I,      3'b101, 7'b0000000, 0,  0,  1'b0, A_SRL, 1'b0, 4);
        run_instr("srai",   OP_I,      3'b101, 7'b0100000, 0,  0,  1'b0, A_SRA, 1'b0, 4);
        run_instr("addi",   OP_I,      3'b000, 7'b0100000, 0,  0,  1'b0, A_ADD, 1'b0, 4);
        run_instr("ori",    OP_I,      3'b110, 7'b1111111, 0,  0,  1'b0, A_OR,  1'b0, 4);
        run_instr("lw0",    OP_LOAD,   3'b010, 7'b0000000, 0,  0,  1'b0, A_ADD, 1'b0, 5);
        run_instr("lw3",    OP_LOAD,   3'b010, 7'b0000000, 0,  3,  1'b0, A_ADD, 1'b0, 8);
        run_instr("sw0",    OP_STORE,  3'b010, 7'b0000000, 0,  0,  1'b0, A_ADD, 1'b0, 4);
        run_instr("sw2",    OP_STORE,  3'b010, 7'b0000000, 0,  2,  1'b0, A_ADD, 1'b0, 6);
        run_instr("beq_z1", OP_BRANCH, 3'b000, 7'b0000000, 0,  0,  1'b1, A_SUB, 1'b1, 3);
        run_instr("beq_z0", OP_BRANCH, 3'b000, 7'b0000000, 0,  0,  1'b0, A_SUB, 1'b0, 3);
        run_instr("bne_z1", OP_BRANCH, 3'b001, 7'b0000000, 0,  0,  1'b1, A_SUB, 1'b0, 3);
        run_instr("bne_z0", OP_BRANCH, 3'b001, 7'b0000000, 0,  0,  1'b0, A_SUB, 1'b1, 3);
        run_instr("jal",    OP_JAL,    3'b111, 7'b1010101, 0,  0,  1'b0, A_ADD, 1'b0, 3);
        run_instr("jalr",   OP_JALR,   3'b000, 7'b0000000, 0,  0,  1'b0, A_ADD, 1'b0, 3);

        // Fetch completing exactly on the timeout cycle: 255 waits, ready on the 256th cycle.
        run_instr("fetch_edge", OP_R,  3'b000, 7'b0000000, 255, 0, 1'b0, A_ADD, 1'b0, 259);
        check("fetch_edge:no_bus_error", bus_error, 0);

        run_illegal("r_f3_010",  OP_R,      3'b010, 7'b0000000, 20);
        run_illegal("r_bad_f7",  OP_R,      3'b111, 7'b0100000, 2);
        run_illegal("slli_f7",   OP_I,      3'b001, 7'b0100000, 2);
        run_illegal("lw_f3",     OP_LOAD,   3'b000, 7'b0000000, 2);
        run_illegal("jalr_f3",   OP_JALR,   3'b001, 7'b0000000, 2);
        run_illegal("br_f3",     OP_BRANCH, 3'b100, 7'b0000000, 2);
        run_illegal("bad_op",    7'b0000000, 3'b000, 7'b0000000, 2);

        // Fetch never answered: 256 cycles without ready, then bus-error trap.
        set_ir(OP_R, 3'b000, 7'b0000000);
        for (int i = 0; i < 256; i++)
            cycle("timeout:fetch", fetch_obs(1'b0), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            e = blank(4'd15); e.berr = 1'b1;
            cycle("timeout:trap", e, 1'b1, 1'b0, 1'b0);
        end
        check("timeout:state", state, 15);
        check("timeout:bus_error", bus_error, 1);
        do_reset("timeout", 4'd15);
        check("timeout:flag_cleared", bus_error, 0);

        // Reset while a store is waiting for the memory.
        run_instr("post_rst", OP_R, 3'b000, 7'b0000000, 0, 0, 1'b0, A_ADD, 1'b0, 4);
        set_ir(OP_STORE, 3'b010, 7'b0000000);
        fetch_decode("sw_rst", 0, 1'b0);
        e = blank(4'd4); e.src_a = 2'd1; e.src_b = 2'd1; e.alu = A_ADD;
        cycle("sw_rst:addr", e, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            e = blank(4'd6); e.mem_req = 1'b1; e.mem_src = 1'b1; e.mem_we = 1'b1;
            cycle("sw_rst:wait", e, 1'b0, 1'b0, 1'b0);
        end
        do_reset("sw_rst", 4'd6);
        check("sw_rst:state", state, 0);
        run_instr("after_rst", OP_JAL, 3'b000, 7'b0000000, 1, 0, 1'b0, A_ADD, 1'b0, 4);

        exp_valid = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
